// File: rtl/envelope_gen.sv
// envelope_gen: ADSR amplitude envelope scaling the waveshaper sample ahead of pwm.
// Optional build macro ENV_RETRIGGER_EN: key_edge while held restarts ATTACK from the current level.
`timescale 1ns/1ps
module envelope_gen #(
    parameter int RATE_DIV      = 12000,
    parameter int ATTACK_STEP   = 8,
    parameter int DECAY_STEP    = 2,
    parameter int SUSTAIN_LEVEL = 160,
    parameter int RELEASE_STEP  = 4
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       en,
    input  logic       gate,
    input  logic       key_edge,
    input  logic [7:0] sample_i,
    output logic [7:0] sample_o,
    output logic [7:0] env_o,
    output logic [2:0] state_o
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ATTACK  = 3'd1;
    localparam logic [2:0] DECAY   = 3'd2;
    localparam logic [2:0] SUSTAIN = 3'd3;
    localparam logic [2:0] RELEASE = 3'd4;

    localparam int            CW      = $clog2(RATE_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(RATE_DIV - 1);
    localparam logic [8:0]    ATK9    = 9'(ATTACK_STEP);
    localparam logic [8:0]    DEC9    = 9'(DECAY_STEP);
    localparam logic [8:0]    REL9    = 9'(RELEASE_STEP);
    localparam logic [8:0]    SUS9    = 9'(SUSTAIN_LEVEL);
    localparam logic [7:0]    SUS8    = 8'(SUSTAIN_LEVEL);

    logic [2:0]    state, state_d;
    logic [7:0]    env, env_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          cnt_clr, tick, active, retrig;
    logic [8:0]    atk_sum, dec_dif, rel_dif, lvl_p1;
    logic [7:0]    atk_lvl, dec_lvl, rel_lvl;
    logic [15:0]   prod;
    logic          unused_prod;

`ifdef ENV_RETRIGGER_EN
    assign retrig = key_edge & gate;
`else
    logic unused_key;
    assign retrig     = 1'b0;
    assign unused_key = key_edge;
`endif

    assign active = (state != IDLE);
    assign tick   = active && (cnt == CNT_MAX);

    // 9-bit intermediates: the carry/borrow bit selects the saturation value.
    assign atk_sum = {1'b0, env} + ATK9;
    assign dec_dif = {1'b0, env} - DEC9;
    assign rel_dif = {1'b0, env} - REL9;
    assign atk_lvl = atk_sum[8] ? 8'hFF : atk_sum[7:0];
    assign dec_lvl = (dec_dif[8] || (dec_dif < SUS9)) ? SUS8 : dec_dif[7:0];
    assign rel_lvl = rel_dif[8] ? 8'h00 : rel_dif[7:0];

    // level+1 makes 255 a unity gain and 0 a full mute after the >>8.
    assign lvl_p1      = {1'b0, env} + 9'd1;
    assign prod        = 16'(sample_i) * 16'(lvl_p1);
    assign unused_prod = ^prod[7:0];

    always_comb begin
        state_d = state;
        env_d   = env;
        cnt_clr = 1'b0;
        case (state)
            IDLE: begin
                if (gate) begin
                    state_d = ATTACK;
                    cnt_clr = 1'b1;
                end
            end
            ATTACK: begin
                if (!gate) begin
                    state_d = RELEASE;
                end else if (retrig) begin
                    cnt_clr = 1'b1;
                end else if (tick) begin
                    env_d = atk_lvl;
                    if (atk_lvl == 8'hFF) state_d = DECAY;
                end
            end
            DECAY: begin
                if (!gate) begin
                    state_d = RELEASE;
                end else if (retrig) begin
                    state_d = ATTACK;
                    cnt_clr = 1'b1;
                end else if (tick) begin
                    env_d = dec_lvl;
                    if (dec_lvl == SUS8) state_d = SUSTAIN;
                end
            end
            SUSTAIN: begin
                env_d = SUS8;
                if (!gate) begin
                    state_d = RELEASE;
                    env_d   = env;
                end else if (retrig) begin
                    state_d = ATTACK;
                    cnt_clr = 1'b1;
                    env_d   = env;
                end
            end
            RELEASE: begin
                if (gate) begin
                    state_d = ATTACK;
                end else if (tick) begin
                    env_d = rel_lvl;
                    if (rel_lvl == 8'h00) state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                env_d   = 8'h00;
                cnt_clr = 1'b1;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt;
        if (cnt_clr)     cnt_d = '0;
        else if (tick)   cnt_d = '0;
        else if (active) cnt_d = cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            env      <= 8'h00;
            cnt      <= '0;
            sample_o <= 8'h00;
        end else if (!en) begin
            state    <= IDLE;
            env      <= 8'h00;
            cnt      <= '0;
            sample_o <= 8'h00;
        end else begin
            state    <= state_d;
            env      <= env_d;
            cnt      <= cnt_d;
            sample_o <= prod[15:8];
        end
    end

    assign env_o   = env;
    assign state_o = state;
endmodule

// File: tb/tb_envelope_gen.sv
// Directed bench for envelope_gen with short ticks so full ADSR cycles stay brief.
`timescale 1ns/1ps
module tb_envelope_gen;
    localparam int RD = 4;

    logic       clk = 1'b0;
    logic       n_rst, en, gate, key_edge;
    logic [7:0] sample_i, sample_o, env_o;
    logic [2:0] state_o;
    int         n_chk = 0;
    int         n_err = 0;

    envelope_gen #(
        .RATE_DIV(RD), .ATTACK_STEP(64), .DECAY_STEP(16),
        .SUSTAIN_LEVEL(128), .RELEASE_STEP(32)
    ) dut (
        .clk(clk), .n_rst(n_rst), .en(en), .gate(gate), .key_edge(key_edge),
        .sample_i(sample_i), .sample_o(sample_o), .env_o(env_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for the next level change, then check level and state.
    task automatic wait_chg(input string tag, input int exp_env, input int exp_st);
        logic [7:0] prev;
        int n;
        prev = env_o;
        n = 0;
        while (env_o == prev && n < 4*RD) begin
            cyc();
            n++;
        end
        check({tag, " env"}, env_o, exp_env);
        check({tag, " state"}, state_o, exp_st);
    endtask

    initial begin
        int dec_vals[8] = '{239, 223, 207, 191, 175, 159, 143, 128};
        int atk_vals[4] = '{64, 128, 192, 255};
        n_rst = 1'b0; en = 1'b1; gate = 1'b1; key_edge = 1'b0; sample_i = 8'd255;
        repeat (3) cyc();
        check("rst env", env_o, 0);
        check("rst sample", sample_o, 0);
        check("rst state", state_o, 0);
        n_rst = 1'b1;
        cyc();
        check("attack entry", state_o, 1);
        check("attack entry env", env_o, 0);
        check("level0 mute", sample_o, 0);
        repeat (RD - 1) cyc();
        check("first tick early", env_o, 0);
        cyc();
        check("first tick", env_o, 64);
        wait_chg("atk2", 128, 1);
        wait_chg("atk3", 192, 1);
        wait_chg("atk sat", 255, 2);
        cyc();
        check("unity gain", sample_o, 255);
        for (int i = 0; i < 8; i++)
            wait_chg($sformatf("dec%0d", i), dec_vals[i], (i == 7) ? 3 : 2);
        sample_i = 8'd200;
        cyc();
        check("sustain scale", sample_o, 100);
        repeat (2*RD) cyc();
        check("sustain hold", env_o, 128);

        gate = 1'b0;
        cyc();
        check("release entry", state_o, 4);
        check("release keep", env_o, 128);
        wait_chg("rel1", 96, 4);
        wait_chg("rel2", 64, 4);
        gate = 1'b1;
        cyc();
        check("regate state", state_o, 1);
        check("regate env", env_o, 64);
        wait_chg("regate tick", 128, 1);

        en = 1'b0;
        cyc();
        check("en0 state", state_o, 0);
        check("en0 env", env_o, 0);
        check("en0 sample", sample_o, 0);
        repeat (2) cyc();
        check("en0 gate ignored", state_o, 0);

        en = 1'b1;
        cyc();
        check("resume", state_o, 1);
        for (int i = 0; i < 4; i++)
            wait_chg($sformatf("ratk%0d", i), atk_vals[i], (i == 3) ? 2 : 1);
        for (int i = 0; i < 8; i++)
            wait_chg($sformatf("rdec%0d", i), dec_vals[i], (i == 7) ? 3 : 2);

        key_edge = 1'b1;
        cyc();
        key_edge = 1'b0;
`ifdef ENV_RETRIGGER_EN
        check("retrig state", state_o, 1);
        check("retrig env", env_o, 128);
        wait_chg("retrig tick", 192, 1);
        wait_chg("retrig sat", 255, 2);
        for (int i = 0; i < 8; i++)
            wait_chg($sformatf("tdec%0d", i), dec_vals[i], (i == 7) ? 3 : 2);
`else
        check("legato state", state_o, 3);
        check("legato env", env_o, 128);
`endif

        gate = 1'b0;
        cyc();
        check("rel entry2", state_o, 4);
        wait_chg("frel1", 96, 4);
        wait_chg("frel2", 64, 4);
        wait_chg("frel3", 32, 4);
        wait_chg("frel4", 0, 0);
        cyc();
        check("idle sample", sample_o, 0);
        repeat (2*RD) cyc();
        check("idle stays", state_o, 0);

        gate = 1'b1;
        cyc();
        wait_chg("pre-reset", 64, 1);
        #2 n_rst = 1'b0;
        #1;
        check("async rst env", env_o, 0);
        check("async rst state", state_o, 0);
        check("async rst sample", sample_o, 0);
        cyc();
        n_rst = 1'b1;
        cyc();
        check("post-reset attack", state_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/envelope_gen.md
# envelope_gen

ADSR amplitude envelope stage inside `synth_top`, placed between the `waveshaper` and `pwm` stages. It takes the 8-bit unsigned sample from the waveshaper and scales it by an 8-bit envelope level. The level follows attack, decay, sustain and release phases, driven by the key gate and stepped on a programmable tick. The scaled sample is registered and feeds the `pwm` `sample` input directly.

## Interface
Parameters:
- `RATE_DIV`, 12000: clk cycles per envelope tick (1 ms at 12 MHz); must be ≥ 2.
- `ATTACK_STEP`, 8: level increment per tick in ATTACK; 1–255.
- `DECAY_STEP`, 2: level decrement per tick in DECAY; 1–255.
- `SUSTAIN_LEVEL`, 160: level held in SUSTAIN; 0–255.
- `RELEASE_STEP`, 4: level decrement per tick in RELEASE; 1–255.

Ports:
- `clk`  in  1  system clock (`hz12M` at top).
- `n_rst`  in  1  reset. One clock; reset is asynchronous and active-low.
- `en`  in  1  synth enable, same signal as the other stages.
- `gate`  in  1  high while any note key is held (keycode ≠ 0).
- `key_edge`  in  1  one-cycle pulse when a new note key is pressed.
- `sample_i`  in  8  unsigned sample from `waveshaper`.
- `sample_o`  out  8  scaled sample to `pwm`.
- `env_o`  out  8  current envelope level.
- `state_o`  out  3  encoding: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.

## Operation
- Reset values: `state_o`=IDLE, `env_o`=0, `sample_o`=0, tick counter=0.
- Tick counter:
  - Counts 0..RATE_DIV-1 while `en`=1 and state ≠ IDLE.
  - `tick` is asserted in the cycle where the count equals RATE_DIV-1; the count then wraps to 0.
- State machine:
  - IDLE: if `gate`=1, go to ATTACK and clear the tick counter.
  - ATTACK: on `tick`, level = min(level+ATTACK_STEP, 255). When the result is 255, go to DECAY.
  - DECAY: on `tick`, level = max(level-DECAY_STEP, SUSTAIN_LEVEL). When the result equals SUSTAIN_LEVEL, go to SUSTAIN.
  - SUSTAIN: level held at SUSTAIN_LEVEL.
  - RELEASE: on `tick`, level = max(level-RELEASE_STEP, 0). When the result is 0, go to IDLE.
- Gate handling:
  - `gate`=0 in ATTACK, DECAY or SUSTAIN: go to RELEASE on the next edge, keeping the current level; the tick counter is not cleared.
  - `gate`=1 in RELEASE: go to ATTACK on the next edge from the current level; the level is not zeroed.
- Gate vs. tick collision: a gate-driven transition takes priority over a tick in the same cycle; that tick's level update is discarded.
- Arithmetic:
  - Level updates use 9-bit intermediates with saturation; no wrap-around is permitted.
  - `sample_o` = (sample_i × (level+1)) >> 8, taken from bits [15:8] of the 16-bit product.
  - So level 255 passes the sample unchanged and level 0 gives 0.
- `en`=0: on the next edge, state=IDLE, level=0, counter=0 and `sample_o`=0, regardless of `gate`. Normal operation resumes when `en` returns high and `gate`=1.

## Timing
- `sample_o` is registered and lags `sample_i` and `env_o` by 1 cycle.
- `env_o` and `state_o` are registered and update on the clk edge where `tick` or the transition condition holds.
- First ATTACK step after a gate rise in IDLE: ATTACK is entered on edge N+1, and the first level change lands RATE_DIV cycles later.
- Reset mid-operation: asynchronous return to the reset values, with no glitch-dependent state retained.
- `key_edge` is sampled only in ATTACK, DECAY and SUSTAIN; it is ignored in IDLE and RELEASE.

## Configuration
- Macro `ENV_RETRIGGER_EN`:
  - Defined: a `key_edge`=1 while `gate`=1 in DECAY or SUSTAIN forces ATTACK on the next edge from the current level and clears the tick counter. In ATTACK it only clears the tick counter.
  - Undefined: `key_edge` is ignored, so note changes while a key is held are legato.
  - The port exists in both builds.

## Test plan
Bench parameters: RATE_DIV=4, ATTACK_STEP=64, DECAY_STEP=16, SUSTAIN_LEVEL=128, RELEASE_STEP=32.
- Reset with `gate`=1 held → `env_o`=0, `sample_o`=0, `state_o`=0 until `n_rst` rises; ATTACK is entered on the first edge after release of reset.
- `en`=1, `gate` rises → `env_o` steps 64, 128, 192, 255 every 4 cycles, then DECAY 239, 223, …, 143, 128, then `state_o`=3.
- SUSTAIN, `sample_i`=200 → `sample_o`=100 one cycle later; with `sample_i`=255 at level 255 → `sample_o`=255.
- `gate` falls in SUSTAIN → RELEASE on the next edge, level 96, 64, 32, 0, then IDLE. `gate` re-raised at level 64 → ATTACK, next tick 128.
- `en` dropped mid-ATTACK at level 128 → next edge: IDLE, `env_o`=0, `sample_o`=0.
- `key_edge` pulse in SUSTAIN with `gate`=1 → ATTACK from 128, next tick 192 (macro defined); state stays 3 (macro undefined).
